// File: rtl/cf_ifft_bfly_1024_8_12.sv
// ---------------------------------------------------------------------------
// cf_ifft_bfly_1024_8_12
//
// Radix-2 inverse DIF butterfly for a 1024-point IFFT with 8-bit complex
// samples and a 16-entry conjugate twiddle ROM. Computes
//   x = a + b
//   y = (a - b) * conj(W_k)
// through a four-stage pipeline (capture, sum/diff + ROM, partial products,
// combine). It also counts valid butterflies per stage (512 per stage,
// 10 stages per frame).
//
// Optional feature: define CF_IFFT_SCALE_EN to arithmetic-shift each
// component of a+b and a-b right by one bit in P2. Over the ten stages this
// gives 1/N normalisation. Latency is the same in both builds.
//
// Ports
//   clock_c  in   1  rising-edge clock
//   i1       in   1  synchronous active-low reset
//   i2       in  16  sample a, {re[15:8], im[7:0]}, two's complement
//   i3       in  16  sample b, same packing
//   i4       in   4  twiddle index k (0..15)
//   i5       in   1  enable; the whole block advances only when high
//   i6       in   1  input valid for i2/i3/i4
//   o1       out 16  x = a+b, {re, im}
//   o2       out 16  y = (a-b)*conj(W_k), {re, im}
//   o3       out  1  output valid
//   o4       out  1  stage-done pulse (512th valid result of a stage)
//   o5       out  4  stage index, 0..9
// ---------------------------------------------------------------------------
module cf_ifft_bfly_1024_8_12 (
    input  logic        clock_c,
    input  logic        i1,
    input  logic [15:0] i2,
    input  logic [15:0] i3,
    input  logic [3:0]  i4,
    input  logic        i5,
    input  logic        i6,
    output logic [15:0] o1,
    output logic [15:0] o2,
    output logic        o3,
    output logic        o4,
    output logic [3:0]  o5
);

    // Conjugate twiddle ROM, {re, im}:
    // re = round(127*cos(pi*k/16)), im = round(127*sin(pi*k/16)).
    function automatic logic [15:0] twiddle(input logic [3:0] k);
        case (k)
            4'd0:    twiddle = 16'h7F00;
            4'd1:    twiddle = 16'h7D19;
            4'd2:    twiddle = 16'h7531;
            4'd3:    twiddle = 16'h6A47;
            4'd4:    twiddle = 16'h5A5A;
            4'd5:    twiddle = 16'h476A;
            4'd6:    twiddle = 16'h3175;
            4'd7:    twiddle = 16'h197D;
            4'd8:    twiddle = 16'h007F;
            4'd9:    twiddle = 16'hE77D;
            4'd10:   twiddle = 16'hCF75;
            4'd11:   twiddle = 16'hB96A;
            4'd12:   twiddle = 16'hA65A;
            4'd13:   twiddle = 16'h9647;
            4'd14:   twiddle = 16'h8B31;
            default: twiddle = 16'h8319;
        endcase
    endfunction

    // Optional halving of one 8-bit component (arithmetic shift).
    function automatic logic [7:0] scale(input logic [7:0] v);
`ifdef CF_IFFT_SCALE_EN
        scale = {v[7], v[7:1]};
`else
        scale = v;
`endif
    endfunction

    // One partial product: operands sign-extended to 16 bits, 16-bit
    // product, and bits [14:7] kept. This drops the Q7 fraction of the
    // twiddle and truncates toward minus infinity.
    function automatic logic [7:0] pprod(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] xe;
        logic signed [15:0] ye;
        logic signed [15:0] p;
        xe = {{8{x[7]}}, x};
        ye = {{8{y[7]}}, y};
        p  = xe * ye;
        pprod = p[14:7];
    endfunction

    // P1: captured inputs
    logic [15:0] p1_a, p1_b;
    logic [3:0]  p1_k;
    logic        p1_v;
    // P2: sum, difference, twiddle
    logic [15:0] p2_s, p2_d, p2_w;
    logic        p2_v;
    // P3: sum passthrough plus the four partial products
    logic [15:0] p3_x;
    logic [7:0]  p3_rr, p3_ii, p3_ri, p3_ir;
    logic        p3_v;
    // Butterflies completed in the current stage
    logic [8:0]  bfly_cnt;

    // Component-wise add/sub with modulo-256 wrap
    logic [7:0] sum_re, sum_im, dif_re, dif_im;
    assign sum_re = p1_a[15:8] + p1_b[15:8];
    assign sum_im = p1_a[7:0]  + p1_b[7:0];
    assign dif_re = p1_a[15:8] - p1_b[15:8];
    assign dif_im = p1_a[7:0]  - p1_b[7:0];

    // NOTE: every register below uses non-blocking assignment, so each stage
    // reads the previous stage's old value and the pipeline shifts exactly
    // one slot per enabled edge, regardless of statement order.
    always_ff @(posedge clock_c) begin
        // NOTE: the synchronous reset is tested ahead of the enable so that
        // it clears everything, in-flight data included, even when i5=0.
        // There is no RAM here, so resetting all state costs nothing.
        if (!i1) begin
            p1_a     <= '0;  p1_b  <= '0;  p1_k  <= '0;  p1_v  <= 1'b0;
            p2_s     <= '0;  p2_d  <= '0;  p2_w  <= '0;  p2_v  <= 1'b0;
            p3_x     <= '0;  p3_rr <= '0;  p3_ii <= '0;
            p3_ri    <= '0;  p3_ir <= '0;  p3_v  <= 1'b0;
            o1       <= '0;  o2    <= '0;  o3    <= 1'b0;
            o4       <= 1'b0;
            o5       <= '0;
            bfly_cnt <= '0;
        end else if (i5) begin
            // P1: capture
            p1_a <= i2;
            p1_b <= i3;
            p1_k <= i4;
            p1_v <= i6;

            // P2: sum/diff (optionally halved) and ROM read
            p2_s <= {scale(sum_re), scale(sum_im)};
            p2_d <= {scale(dif_re), scale(dif_im)};
            p2_w <= twiddle(p1_k);
            p2_v <= p1_v;

            // P3: partial products of d * conj(W); the ROM already holds the
            // conjugate-friendly sign, so re = dr*wr - di*wi, im = dr*wi + di*wr
            p3_x  <= p2_s;
            p3_rr <= pprod(p2_d[15:8], p2_w[15:8]);
            p3_ii <= pprod(p2_d[7:0],  p2_w[7:0]);
            p3_ri <= pprod(p2_d[15:8], p2_w[7:0]);
            p3_ir <= pprod(p2_d[7:0],  p2_w[15:8]);
            p3_v  <= p2_v;

            // P4: combine
            o1 <= p3_x;
            o2 <= {p3_rr - p3_ii, p3_ri + p3_ir};
            o3 <= p3_v;

            // Stage bookkeeping. Only valid results loading P4 are counted.
            // The done flag lasts exactly one enabled edge.
            if (p3_v) begin
                if (bfly_cnt == 9'd511) begin
                    bfly_cnt <= '0;
                    o4       <= 1'b1;
                    o5       <= (o5 == 4'd9) ? 4'd0 : o5 + 4'd1;
                end else begin
                    bfly_cnt <= bfly_cnt + 9'd1;
                    o4       <= 1'b0;
                end
            end else begin
                o4 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cf_ifft_bfly_1024_8_12.sv
// ---------------------------------------------------------------------------
// tb_cf_ifft_bfly_1024_8_12
//
// Directed testbench for cf_ifft_bfly_1024_8_12. It covers reset, butterfly
// arithmetic with hand-computed vectors, enable stalls, reset while data is
// in flight, and stage counting across a full 1024-point frame.
// Expected values follow the build (CF_IFFT_SCALE_EN defined or not).
// ---------------------------------------------------------------------------
module tb_cf_ifft_bfly_1024_8_12;

    logic        clock_c = 1'b0;
    logic        i1, i5, i6;
    logic [15:0] i2, i3;
    logic [3:0]  i4;
    logic [15:0] o1, o2;
    logic        o3, o4;
    logic [3:0]  o5;

    int checks = 0;
    int errors = 0;

    cf_ifft_bfly_1024_8_12 dut (
        .clock_c (clock_c),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .i4      (i4),
        .i5      (i5),
        .i6      (i6),
        .o1      (o1),
        .o2      (o2),
        .o3      (o3),
        .o4      (o4),
        .o5      (o5)
    );

    always #5 clock_c = ~clock_c;

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock_c);
        #1;
    endtask

    task automatic idle_inputs();
        i2 = 16'h0000;
        i3 = 16'h0000;
        i4 = 4'd0;
        i6 = 1'b0;
    endtask

    task automatic test_reset();
        i1 = 1'b0;
        i5 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            i2 = 16'($urandom);
            i3 = 16'($urandom);
            i4 = 4'($urandom);
            i6 = 1'($urandom);
            step();
        end
        checks++; if (o1 !== 16'h0000) begin errors++; $display("FAIL reset_o1: got %h want 0000", o1); end
        checks++; if (o2 !== 16'h0000) begin errors++; $display("FAIL reset_o2: got %h want 0000", o2); end
        checks++; if (o3 !== 1'b0)     begin errors++; $display("FAIL reset_o3: got %b want 0", o3); end
        checks++; if (o4 !== 1'b0)     begin errors++; $display("FAIL reset_o4: got %b want 0", o4); end
        checks++; if (o5 !== 4'd0)     begin errors++; $display("FAIL reset_o5: got %0d want 0", o5); end
        i1 = 1'b1;
        idle_inputs();
    endtask

    // Issue one valid butterfly, then idle slots. The valid must be absent
    // after enabled edges 2 and 3 and present with the expected data after
    // edge 4.
    task automatic run_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] k, input logic [15:0] ex, input logic [15:0] ey);
        i5 = 1'b1;
        i2 = a; i3 = b; i4 = k; i6 = 1'b1;
        step();
        idle_inputs();
        for (int n = 2; n <= 3; n++) begin
            step();
            checks++;
            if (o3 !== 1'b0) begin errors++; $display("FAIL %s_early_valid edge %0d: got %b want 0", name, n, o3); end
        end
        step();
        checks++; if (o3 !== 1'b1) begin errors++; $display("FAIL %s_o3: got %b want 1", name, o3); end
        checks++; if (o1 !== ex)   begin errors++; $display("FAIL %s_o1: got %h want %h", name, o1, ex); end
        checks++; if (o2 !== ey)   begin errors++; $display("FAIL %s_o2: got %h want %h", name, o2, ey); end
    endtask

    task automatic test_butterfly();
`ifdef CF_IFFT_SCALE_EN
        run_vec("k0_basic", 16'h1000, 16'h0800, 4'd0,  16'h0C00, 16'h0300);
        run_vec("k8",       16'h1000, 16'h0000, 4'd8,  16'h0800, 16'h0007);
        run_vec("wrap",     16'h7F00, 16'h0100, 4'd0,  16'hC000, 16'h3E00);
        run_vec("neg_diff", 16'h0000, 16'h1000, 4'd0,  16'h0800, 16'hF800);
        run_vec("k4_imag",  16'h0010, 16'h0000, 4'd4,  16'h0008, 16'hFB05);
`else
        run_vec("k0_basic", 16'h1000, 16'h0800, 4'd0,  16'h1800, 16'h0700);
        run_vec("k8",       16'h1000, 16'h0000, 4'd8,  16'h1000, 16'h000F);
        run_vec("wrap",     16'h7F00, 16'h0100, 4'd0,  16'h8000, 16'h7D00);
        run_vec("neg_diff", 16'h0000, 16'h1000, 4'd0,  16'h1000, 16'hF000);
        run_vec("k4_imag",  16'h0010, 16'h0000, 4'd4,  16'h0010, 16'hF50B);
`endif
    endtask

    task automatic test_stall();
        logic [15:0] ex, ey;
`ifdef CF_IFFT_SCALE_EN
        ex = 16'h0C00; ey = 16'h0300;
`else
        ex = 16'h1800; ey = 16'h0700;
`endif
        i5 = 1'b1;
        idle_inputs();
        repeat (4) step();
        i2 = 16'h1000; i3 = 16'h0800; i4 = 4'd0; i6 = 1'b1;
        step();
        idle_inputs();
        i5 = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (o3 !== 1'b0 || o1 !== 16'h0000) begin
                errors++; $display("FAIL stall_frozen cycle %0d: got o3=%b o1=%h want o3=0 o1=0000", n, o3, o1);
            end
        end
        i5 = 1'b1;
        for (int n = 2; n <= 3; n++) begin
            step();
            checks++;
            if (o3 !== 1'b0) begin errors++; $display("FAIL stall_early_valid edge %0d: got %b want 0", n, o3); end
        end
        step();
        checks++; if (o3 !== 1'b1) begin errors++; $display("FAIL stall_o3: got %b want 1", o3); end
        checks++; if (o1 !== ex)   begin errors++; $display("FAIL stall_o1: got %h want %h", o1, ex); end
        checks++; if (o2 !== ey)   begin errors++; $display("FAIL stall_o2: got %h want %h", o2, ey); end
        // Outputs hold while disabled, then the result leaves after one enabled edge.
        i5 = 1'b0;
        repeat (2) step();
        checks++;
        if (o3 !== 1'b1 || o1 !== ex) begin
            errors++; $display("FAIL stall_hold_out: got o3=%b o1=%h want o3=1 o1=%h", o3, o1, ex);
        end
        i5 = 1'b1;
        step();
        checks++; if (o3 !== 1'b0) begin errors++; $display("FAIL stall_once: got o3=%b want 0", o3); end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] ex;
`ifdef CF_IFFT_SCALE_EN
        ex = 16'h0C00;
`else
        ex = 16'h1800;
`endif
        i5 = 1'b1;
        i2 = 16'h1000; i3 = 16'h0800; i4 = 4'd0; i6 = 1'b1;
        repeat (4) step();
        checks++;
        if (o3 !== 1'b1 || o1 !== ex) begin
            errors++; $display("FAIL midrst_pre: got o3=%b o1=%h want o3=1 o1=%h", o3, o1, ex);
        end
        // Reset while disabled; it must still act.
        i5 = 1'b0;
        i1 = 1'b0;
        step();
        checks++;
        if (o1 !== 16'h0000 || o2 !== 16'h0000 || o3 !== 1'b0 || o4 !== 1'b0 || o5 !== 4'd0) begin
            errors++; $display("FAIL midrst_clear: got o1=%h o2=%h o3=%b o4=%b o5=%0d want all zero", o1, o2, o3, o4, o5);
        end
        i1 = 1'b1;
        i5 = 1'b1;
        idle_inputs();
        for (int n = 1; n <= 4; n++) begin
            step();
            checks++;
            if (o3 !== 1'b0 || o1 !== 16'h0000) begin
                errors++; $display("FAIL midrst_discard edge %0d: got o3=%b o1=%h want o3=0 o1=0000", n, o3, o1);
            end
        end
    endtask

    // 5120 valid butterflies with random valid gaps and enable stalls.
    // A four-deep valid model predicts o3, o4 and o5 on every edge.
    task automatic test_stage_count();
        logic [3:0] vp;
        logic       en, v, exp_o4;
        int         issued, cnt, stage, pulses, edges, local_err;
        vp = '0; exp_o4 = 1'b0;
        issued = 0; cnt = 0; stage = 0; pulses = 0; edges = 0; local_err = 0;
        i1 = 1'b0; i5 = 1'b0;
        step();
        i1 = 1'b1;
        while ((issued < 5120 || vp != 4'b0000) && edges < 20000 && local_err < 20) begin
            en = ($urandom_range(0, 7) != 0);
            v  = (issued < 5120) && ($urandom_range(0, 3) != 0);
            i5 = en;
            i6 = v;
            i2 = 16'($urandom);
            i3 = 16'($urandom);
            i4 = 4'($urandom);
            step();
            edges++;
            if (en) begin
                vp = {vp[2:0], v};
                if (v) issued++;
                exp_o4 = 1'b0;
                if (vp[3]) begin
                    cnt++;
                    if (cnt == 512) begin
                        cnt    = 0;
                        exp_o4 = 1'b1;
                        stage  = (stage == 9) ? 0 : stage + 1;
                    end
                end
                if (o4 === 1'b1) pulses++;
            end
            checks++;
            if (o3 !== vp[3] || o4 !== exp_o4 || o5 !== 4'(stage)) begin
                errors++; local_err++;
                $display("FAIL stage_edge %0d: got o3=%b o4=%b o5=%0d want o3=%b o4=%b o5=%0d",
                         edges, o3, o4, o5, vp[3], exp_o4, stage);
            end
        end
        checks++;
        if (issued != 5120 || vp != 4'b0000) begin
            errors++; $display("FAIL stage_budget: issued %0d of 5120 within %0d edges", issued, edges);
        end
        checks++; if (pulses != 10) begin errors++; $display("FAIL stage_pulses: got %0d want 10", pulses); end
        checks++; if (o5 !== 4'd0)  begin errors++; $display("FAIL stage_final_o5: got %0d want 0", o5); end
        idle_inputs();
        i5 = 1'b1;
    endtask

    initial begin
        i1 = 1'b0;
        i5 = 1'b0;
        idle_inputs();
        test_reset();
        test_butterfly();
        test_stall();
        test_reset_midflight();
        test_stage_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cf_ifft_bfly_1024_8_12.md
CF_IFFT_BFLY_1024_8_12 -- requirements
Module: cf_ifft_bfly_1024_8_12

Interface
REQ-001 The block SHALL expose these ports: clock_c  in  1  rising-edge clock, sole clock domain.
REQ-002 i1  in  1  reset; synchronous, active-low.
REQ-003 i2  in  16  sample a = {re[15:8], im[7:0]}, two's complement.
REQ-004 i3  in  16  sample b, same packing as i2.
REQ-005 i4  in  4  twiddle index k, 0..15.
REQ-006 i5  in  1  enable; pipeline, ROM and counters advance only on edges with i5=1.
REQ-007 i6  in  1  input valid, qualifies i2/i3/i4.
REQ-008 o1  out  16  upper output x = a+b, packed {re, im}.
REQ-009 o2  out  16  lower output y = (a-b)*conj(W_k), packed {re, im}.
REQ-010 o3  out  1  output valid.
REQ-011 o4  out  1  stage-done flag.
REQ-012 o5  out  4  stage index, 0..9.

Function
REQ-013 Inverse decimation-in-frequency radix-2 butterfly: x = a+b, y = (a-b)*conj(W_k).
REQ-014 Conjugate twiddle ROM: re = round(127*cos(pi*k/16)); im = round(127*sin(pi*k/16)); k=8 gives (0,127).
REQ-015 Add/subtract on each 8-bit component modulo 2^8 (wrap, no saturation).
REQ-016 Complex multiply with d = a-b: re = dr*wr - di*wi; im = dr*wi + di*wr.
REQ-017 Each partial product: both operands sign-extended to 16 bits, 16-bit product, bits [14:7] kept; combining add/sub modulo 2^8.
REQ-018 Four registered stages, each advancing only when i5=1: P1 input capture; P2 sum/diff plus ROM read; P3 four partial products; P4 combine into o1/o2.
REQ-019 Latency is exactly 4 enabled edges from capture of i2/i3/i4/i6 to o1/o2/o3.
REQ-020 i6 travels through a 4-deep valid shift register alongside the data; o3 is its P4 copy.
REQ-021 With i5=0, every register holds, including outputs, valids and counters; no data is dropped or duplicated.
REQ-022 Invalid slots (i6=0) still propagate data but are never counted.
REQ-023 9-bit butterfly counter increments on each enabled edge that loads P4 with valid=1.
REQ-024 o4 is registered and set to 1 on the enabled edge that loads the 512th valid result of a stage (counter = 511); it clears on the next enabled edge.
REQ-025 On that same edge the butterfly counter wraps to 0 and o5 increments; o5 wraps 9 -> 0, which is 10 stages per 1024-point frame.
REQ-026 A gap in i6 mid-stage only delays completion; counts are never lost.

Reset
REQ-027 On a rising edge with i1=0, all pipeline data and valids clear to 0; o1=o2=16'h0000, o3=o4=0, o5=0, butterfly counter=0.
REQ-028 Reset has priority over i5: it acts even when i5=0.
REQ-029 Reset mid-operation discards all in-flight butterflies; outputs are valid again no earlier than 4 enabled edges after release.

Configuration
REQ-030 With macro CF_IFFT_SCALE_EN defined, each component of a+b and a-b is arithmetic-shifted right by 1 in P2, before output and before the multiply; over 10 stages this gives 1/N normalisation.
REQ-031 Without CF_IFFT_SCALE_EN, no shift is applied and latency is unchanged in both builds.

Verification
REQ-032 Reset: i1=0 for 3 edges with random inputs and i5=1 -> o1=o2=0000, o3=o4=0, o5=0.
REQ-033 No scale, k=0, a=1000, b=0800, i6=1, i5=1 -> 4 edges later o1=1800, o2=0700, o3=1.
REQ-034 No scale, k=8, a=1000, b=0000 -> o1=1000, o2=000F; wrap check a=7F00, b=0100, k=0 -> o1=8000.
REQ-035 Vector of REQ-033 with i5 dropped for 3 edges after capture -> outputs frozen; result appears on the 4th enabled edge, exactly once.
REQ-036 5120 valid butterflies with random i6 gaps -> o4 pulses on every 512th valid result, o5 steps 0..9 then 0, and no pulse occurs on invalid slots.
REQ-037 CF_IFFT_SCALE_EN build, k=0, a=1000, b=0800 -> o1=0C00, o2=0300.
